dmem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port data memory. It shares the memory between the CPU datapath's load/store path and an external loader/debug port. It sits between the datapath (Mem_Read/Mem_Write, ALU result as address, Read_Data_2 as write data) and the data memory. The CPU is frozen via a stall while its access is pending or the port is busy.

---
 rtl/dmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port data memory (CPU load/store vs ext loader).
// Optional ext anti-starvation counter enabled by defining DMEM_ARB_FAIRNESS_EN.
module dmem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, CPU_ISSUE, CPU_DONE, EXT_ISSUE, EXT_DONE} state_t;

  state_t state_reg, state_next;
  logic   cpu_pend;
  logic   grant_cpu;
  logic   grant_ext;
  logic   ext_turn;

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("dmem_arbiter: STARVE_MAX must be in 1..15");
  end

  assign cpu_pend = cpu_rd | cpu_wr;

`ifdef DMEM_ARB_FAIRNESS_EN
  logic [3:0] starve_reg;

  assign ext_turn = (starve_reg == 4'(STARVE_MAX));

  // Counts CPU wins that left a waiting ext requester behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_reg <= 4'd0;
    end else if (state_reg == IDLE) begin
      if (!ext_req || grant_ext) begin
        starve_reg <= 4'd0;
      end else if (grant_cpu) begin
        starve_reg <= starve_reg + 4'd1;
      end
    end
  end
`else
  assign ext_turn = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_cpu) begin
          state_next = CPU_ISSUE;
        end else if (grant_ext) begin
          state_next = EXT_ISSUE;
        end
      end
      CPU_ISSUE: state_next = CPU_DONE;
      CPU_DONE:  state_next = IDLE;
      EXT_ISSUE: state_next = EXT_DONE;
      EXT_DONE:  state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    grant_cpu = 1'b0;
    grant_ext = 1'b0;
    if (state_reg == IDLE) begin
      if (cpu_pend && !(ext_req && ext_turn)) begin
        grant_cpu = 1'b1;
      end else if (ext_req) begin
        grant_ext = 1'b1;
      end
    end
    cpu_stall = cpu_pend && (state_reg != CPU_DONE);
    ext_ack   = (state_reg == EXT_DONE);
  end

  // Memory port and read-data registers; a simultaneous CPU rd+wr is performed as a write only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      ext_rdata <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_cpu) begin
            mem_rd    <= cpu_rd & ~cpu_wr;
            mem_wr    <= cpu_wr;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
          end else if (grant_ext) begin
            mem_rd    <= ~ext_we;
            mem_wr    <= ext_we;
            mem_addr  <= ext_addr;
            mem_wdata <= ext_wdata;
          end else begin
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
          end
        end
        CPU_ISSUE: begin
          if (mem_rd) begin
            cpu_rdata <= mem_rdata;
          end
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
        end
        EXT_ISSUE: begin
          if (mem_rd) begin
            ext_rdata <= mem_rdata;
          end
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed protocol checks, then random CPU/ext traffic
// against a transaction-level memory model updated in completion order.
module tb_dmem_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
`ifdef DMEM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  localparam int MAX_CPU_WAIT = FAIR ? 5 : 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cpu_rd, cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              cpu_stall;
  logic              ext_req, ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata, ext_rdata;
  logic              ext_ack;
  logic              mem_rd, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_MAX(STARVE_MAX), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ack(ext_ack), .ext_rdata(ext_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Data memory: combinational read, write on the rising edge.
  logic [31:0] ram [256] = '{default: 32'h0};
  always @(posedge clk) if (mem_wr) ram[mem_addr[7:0]] <= mem_wdata;
  assign mem_rdata = ram[mem_addr[7:0]];

  logic [31:0] ref_mem [256];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cpu_rd = 1'b0; cpu_wr = 1'b0; ext_req = 1'b0;
      @(negedge clk);
    end
  endtask

  // Runs one CPU access; returns at the negedge of the cycle where the stall dropped.
  task automatic cpu_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output int stall_n, output int wr_n,
                        output int rd_n);
    @(posedge clk); #1;
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    stall_n = 0; wr_n = 0; rd_n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_wr) wr_n++;
      if (mem_rd) rd_n++;
      if (!cpu_stall) break;
      stall_n++;
    end
  endtask

  task automatic ext_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat);
    @(posedge clk); #1;
    ext_req = 1'b1; ext_we = we; ext_addr = addr; ext_wdata = wdata;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (ext_ack) break;
    end
    @(posedge clk); #1;
    ext_req = 1'b0;
    @(negedge clk);
    check("ext_ack_one_cycle", 32'(ext_ack), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, w, r, lat;
    byte grants[$];
    int n_cpu, n_ext, ack_seen;
    logic        c_busy, c_rd, c_wr, e_busy, e_we, e_cool;
    logic [31:0] c_addr, c_wdata, e_addr, e_wdata, exp_cpu_rdata, exp_ext_rdata;
    int          c_wait, e_wait, pick;

    for (int a = 0; a < 256; a++) ref_mem[a] = 32'h0;

    // Reset values with a CPU load already requested
    rst_n = 1'b0; cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h10; cpu_wdata = 32'h0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = 32'h0; ext_wdata = 32'h0;
    #12;
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_ext_ack", 32'(ext_ack), 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_ext_rdata", ext_rdata, 32'h0);
    check("rst_cpu_stall", 32'(cpu_stall), 32'd1);
    check("rst_mem_addr", mem_addr, 32'h0);
    cpu_rd = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    bus_idle(2);

    // CPU store then load
    cpu_op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, s, w, r);
    check("st_stall_cycles", 32'(s), 32'd2);
    check("st_mem_wr_cycles", 32'(w), 32'd1);
    check("st_ram", ram[8'h10], 32'hDEADBEEF);
    ref_mem[8'h10] = 32'hDEADBEEF;
    cpu_op(1'b1, 1'b0, 32'h10, 32'h0, s, w, r);
    check("ld_stall_cycles", 32'(s), 32'd2);
    check("ld_mem_rd_cycles", 32'(r), 32'd1);
    check("ld_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    bus_idle(2);

    // External load with the CPU idle
    ext_op(1'b0, 32'h10, 32'h0, lat);
    check("ext_ld_latency", 32'(lat), 32'd3);
    check("ext_ld_rdata", ext_rdata, 32'hDEADBEEF);
    bus_idle(2);

    // Both requesters held for 30 cycles
    @(posedge clk); #1;
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h10;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h10;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cpu_rd && !cpu_stall) grants.push_back("C");
      if (ext_ack) grants.push_back("E");
      if (i < 29) begin @(posedge clk); #1; end
    end
    n_cpu = 0; n_ext = 0;
    foreach (grants[k]) if (grants[k] == "C") n_cpu++; else n_ext++;
    check("sim_slots", 32'(grants.size()), 32'd10);
    check("sim_cpu_grants", 32'(n_cpu), FAIR ? 32'd8 : 32'd10);
    check("sim_ext_acks", 32'(n_ext), FAIR ? 32'd2 : 32'd0);
    for (int k = 0; k < grants.size() && k < 10; k++) begin
      byte exp_g;
      exp_g = (FAIR && ((k + 1) % (STARVE_MAX + 1) == 0)) ? "E" : "C";
      check($sformatf("sim_order[%0d]", k), 32'(grants[k]), 32'(exp_g));
    end
    bus_idle(2);

    // Reset during the issue cycle of an ext write
    @(posedge clk); #1;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h20; ext_wdata = 32'h12345678;
    @(negedge clk);
    check("rmw_idle_mem_wr", 32'(mem_wr), 32'd0);
    @(posedge clk); #1;
    check("rmw_issue_mem_wr", 32'(mem_wr), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rmw_strobe_drop", 32'(mem_wr), 32'd0);
    @(negedge clk); ext_req = 1'b0;
    @(posedge clk); #1;
    check("rmw_ram_during_rst", ram[8'h20], 32'h0);
    @(negedge clk); rst_n = 1'b1;
    ack_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ext_ack) ack_seen = 1;
    end
    check("rmw_no_ack", 32'(ack_seen), 32'd0);
    check("rmw_ram_after", ram[8'h20], 32'h0);
    cpu_op(1'b1, 1'b0, 32'h20, 32'h0, s, w, r);
    check("rmw_idle_after_rst", 32'(s), 32'd2);
    check("rmw_ld_rdata", cpu_rdata, 32'h0);

    // Random traffic from both requesters
    exp_cpu_rdata = 32'h0; exp_ext_rdata = 32'h0;
    c_busy = 1'b0; e_busy = 1'b0; e_cool = 1'b0;
    c_rd = 1'b0; c_wr = 1'b0; e_we = 1'b0;
    c_addr = 0; c_wdata = 0; e_addr = 0; e_wdata = 0; c_wait = 0; e_wait = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc >= 500 && !c_busy && !e_busy) break;
      @(posedge clk); #1;
      if (!c_busy && cyc < 500 && $urandom_range(9) < 6) begin
        pick = $urandom_range(15);
        c_wr = (pick < 7); c_rd = (pick >= 6);
        c_addr = $urandom_range(63); c_wdata = $urandom;
        c_busy = 1'b1; c_wait = 0;
      end
      cpu_rd = c_busy & c_rd; cpu_wr = c_busy & c_wr;
      cpu_addr = c_addr; cpu_wdata = c_wdata;
      if (!e_busy) begin
        if (!e_cool && cyc < 500 && $urandom_range(3) == 0) begin
          e_we = $urandom_range(1) == 1; e_addr = $urandom_range(63); e_wdata = $urandom;
          e_busy = 1'b1; e_wait = 0;
        end
        e_cool = 1'b0;
      end
      ext_req = e_busy; ext_we = e_we; ext_addr = e_addr; ext_wdata = e_wdata;
      @(negedge clk);
      if (c_busy) begin
        if (cpu_stall) begin
          c_wait++;
          if (c_wait > MAX_CPU_WAIT) begin
            check("rnd_cpu_stall_bound", 32'(c_wait), 32'(MAX_CPU_WAIT));
            c_busy = 1'b0;
          end
        end else begin
          check("rnd_cpu_latency", 32'(c_wait >= 2 && c_wait <= MAX_CPU_WAIT), 32'd1);
          if (c_wr) ref_mem[c_addr[7:0]] = c_wdata;
          else exp_cpu_rdata = ref_mem[c_addr[7:0]];
          check("rnd_cpu_rdata", cpu_rdata, exp_cpu_rdata);
          c_busy = 1'b0;
        end
      end else begin
        check("rnd_stall_when_idle", 32'(cpu_stall), 32'd0);
      end
      if (e_busy) begin
        if (ext_ack) begin
          if (e_we) ref_mem[e_addr[7:0]] = e_wdata;
          else exp_ext_rdata = ref_mem[e_addr[7:0]];
          check("rnd_ext_rdata", ext_rdata, exp_ext_rdata);
          e_busy = 1'b0; e_cool = 1'b1;
        end else begin
          e_wait++;
          if (e_wait > 300) begin
            check("rnd_ext_wait_bound", 32'(e_wait), 32'd300);
            e_busy = 1'b0;
          end
        end
      end else if (ext_ack) begin
        check("rnd_spurious_ack", 32'(ext_ack), 32'd0);
      end
    end
    bus_idle(2);
    for (int a = 0; a < 64; a++) check($sformatf("ram_final[%0d]", a), ram[a], ref_mem[a]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
